// File: rtl/rpn_stack_core.sv
// RPN calculator core: DEPTH x W operand stack, two-cycle ALU ops, single-level undo
// and sticky error status. Outputs are decoded from registers only.
module rpn_stack_core #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enter,
  input  logic                       undo,
  input  logic                       mode,
  input  logic [2:0]                 op,
  input  logic [W-1:0]               data_in,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic [3:0]                 flags,
  output logic [2:0]                 status,
  output logic                       busy
);
  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
  localparam logic [W:0]     SH_MAX  = (W+1)'(W);

  localparam logic [2:0] ST_OK = 3'd0, ST_EXEC = 3'd1, ST_FULL = 3'd2,
                         ST_UF = 3'd3, ST_NO_UNDO = 3'd4;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [2:0] {
    C_NONE, C_PUSH, C_OP, C_WB, C_UNDO, C_E_FULL, C_E_UF, C_E_UNDO
  } cmd_t;

  typedef struct packed {
    logic         vld;
    logic         is_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } undo_rec_t;

  state_t          state_q, state_d;
  cmd_t            cmd;
  undo_rec_t       rec;
  logic [SPW-1:0]  sp;
  logic [W-1:0]    stk [DEPTH];
  logic [W-1:0]    a_q, b_q, res;
  logic [2:0]      op_q;
  logic [W:0]      sum;
  logic [2*W-1:0]  prod;
  logic            c_f, v_f;
  logic [IW-1:0]   i_sp, i_top, i_sec;

  assign i_sp  = IW'(sp);
  assign i_top = IW'(sp - 1'b1);
  assign i_sec = IW'(sp - SP_TWO);

  assign top    = (sp == '0) ? '0 : stk[i_top];
  assign depth  = sp;
  assign busy   = (state_q == EXEC);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Undo takes priority over enter; both are dropped while in EXEC.
  always_comb begin
    state_d = state_q;
    cmd     = C_NONE;
    case (state_q)
      IDLE: begin
        if (undo) begin
          cmd = rec.vld ? C_UNDO : C_E_UNDO;
        end else if (enter) begin
          if (!mode)              cmd = (sp == SP_FULL) ? C_E_FULL : C_PUSH;
          else if (sp < SP_TWO)   cmd = C_E_UF;
          else begin
            cmd     = C_OP;
            state_d = EXEC;
          end
        end
      end
      default: begin
        cmd     = C_WB;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q};
    prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    res  = '0;
    c_f  = 1'b0;
    v_f  = 1'b0;
    case (op_q)
      3'd0: begin
        res = sum[W-1:0];
        c_f = sum[W];
        v_f = (a_q[W-1] == b_q[W-1]) && (res[W-1] != a_q[W-1]);
      end
      3'd1: begin
        res = a_q - b_q;
        c_f = (a_q < b_q);
        v_f = (a_q[W-1] != b_q[W-1]) && (res[W-1] != a_q[W-1]);
      end
      3'd2: begin
        res = prod[W-1:0];
        c_f = |prod[2*W-1:W];
      end
      3'd3: res = a_q & b_q;
      3'd4: res = a_q | b_q;
      3'd5: res = a_q ^ b_q;
      3'd6: res = ({1'b0, b_q} >= SH_MAX) ? '0 : (a_q << b_q);
      default: res = ({1'b0, b_q} >= SH_MAX) ? '0 : (a_q >> b_q);
    endcase
  end

  // Stack contents carry no reset; reset only has to block writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (cmd)
        C_PUSH: stk[i_sp]  <= data_in;
        C_WB:   stk[i_sec] <= res;
        C_UNDO: if (rec.is_op) begin
          stk[i_top] <= rec.a;
          stk[i_sp]  <= rec.b;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp     <= '0;
      flags  <= '0;
      status <= ST_OK;
      rec    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
    end else begin
      case (cmd)
        C_PUSH: begin
          sp        <= sp + 1'b1;
          status    <= ST_OK;
          rec.vld   <= 1'b1;
          rec.is_op <= 1'b0;
        end
        C_OP: begin
          a_q    <= stk[i_sec];
          b_q    <= stk[i_top];
          op_q   <= op;
          status <= ST_EXEC;
        end
        C_WB: begin
          sp     <= sp - 1'b1;
          flags  <= {res[W-1], (res == '0), c_f, v_f};
          status <= ST_OK;
          rec    <= '{vld: 1'b1, is_op: 1'b1, a: a_q, b: b_q};
        end
        C_UNDO: begin
          sp      <= rec.is_op ? sp + 1'b1 : sp - 1'b1;
          flags   <= '0;
          status  <= ST_OK;
          rec.vld <= 1'b0;
        end
        C_E_FULL: status <= ST_FULL;
        C_E_UF:   status <= ST_UF;
        C_E_UNDO: status <= ST_NO_UNDO;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_stack_core.sv
// Scenario bench for rpn_stack_core (W=16, DEPTH=4): expected snapshots are queued as
// stimulus is driven, DUT snapshots are queued after each edge, and each scenario drains both.
module tb_rpn_stack_core;
  typedef struct packed {
    logic [15:0] top;
    logic [2:0]  depth;
    logic [3:0]  flags;
    logic [2:0]  status;
    logic        busy;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enter = 1'b0, undo = 1'b0, mode = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] data_in = '0;
  logic [15:0] top;
  logic [2:0]  depth;
  logic [3:0]  flags;
  logic [2:0]  status;
  logic        busy;

  snap_t exp_q[$], obs_q[$];
  string nm_q[$];
  int    n_vec = 0, n_err = 0;

  rpn_stack_core #(.W(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enter(enter), .undo(undo), .mode(mode), .op(op),
    .data_in(data_in), .top(top), .depth(depth), .flags(flags), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [15:0] t, input logic [2:0] d, input logic [3:0] f,
                               input logic [2:0] s, input logic b);
    mk = {t, d, f, s, b};
  endfunction

  task automatic step(input string nm, input logic e, input logic u, input logic m,
                      input logic [2:0] o, input logic [15:0] d, input logic rst, input snap_t ex);
    @(negedge clk);
    enter = e; undo = u; mode = m; op = o; data_in = d; reset = rst;
    exp_q.push_back(ex);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    obs_q.push_back({top, depth, flags, status, busy});
    enter = 1'b0; undo = 1'b0; reset = 1'b0;
  endtask

  task automatic push(input string nm, input logic [15:0] v, input snap_t ex);
    step(nm, 1'b1, 1'b0, 1'b0, 3'd0, v, 1'b0, ex);
  endtask
  task automatic opc(input string nm, input logic [2:0] o, input snap_t ex);
    step(nm, 1'b1, 1'b0, 1'b1, o, 16'h0, 1'b0, ex);
  endtask
  task automatic idle(input string nm, input snap_t ex);
    step(nm, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, ex);
  endtask
  task automatic und(input string nm, input snap_t ex);
    step(nm, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, ex);
  endtask
  task automatic rst(input string nm);
    step(nm, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, mk(16'h0, 3'd0, 4'b0, 3'd0, 1'b0));
  endtask

  task automatic test_reset;
    rst("reset");
    idle("reset_hold", mk(16'h0, 3'd0, 4'b0, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_add;
    push("add_p1", 16'h0003, mk(16'h0003, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("add_p2", 16'h0005, mk(16'h0005, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("add_exec", 3'd0,    mk(16'h0005, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("add_wb",           mk(16'h0008, 3'd1, 4'b0000, 3'd0, 1'b0));
    idle("add_settle",       mk(16'h0008, 3'd1, 4'b0000, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_overflow;
    rst("ovf_rst");
    push("ovf_p1", 16'h7FFF, mk(16'h7FFF, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("ovf_p2", 16'h0001, mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("ovf_exec", 3'd0,    mk(16'h0001, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("ovf_add_wb",       mk(16'h8000, 3'd1, 4'b1001, 3'd0, 1'b0));
    und("ovf_undo",          mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("ovf_exec2", 3'd0,   mk(16'h0001, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("ovf_add_wb2",      mk(16'h8000, 3'd1, 4'b1001, 3'd0, 1'b0));
    push("sub_p1", 16'h0000, mk(16'h0000, 3'd2, 4'b1001, 3'd0, 1'b0));
    push("sub_p2", 16'h0001, mk(16'h0001, 3'd3, 4'b1001, 3'd0, 1'b0));
    opc("sub_exec", 3'd1,    mk(16'h0001, 3'd3, 4'b1001, 3'd1, 1'b1));
    idle("sub_wb",           mk(16'hFFFF, 3'd2, 4'b1010, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_errors;
    rst("full_rst");
    for (int i = 1; i <= 4; i++)
      push("full_fill", 16'(i), mk(16'(i), 3'(i), 4'b0000, 3'd0, 1'b0));
    push("full_reject", 16'h0005, mk(16'h0004, 3'd4, 4'b0000, 3'd2, 1'b0));
    idle("full_sticky",           mk(16'h0004, 3'd4, 4'b0000, 3'd2, 1'b0));
    rst("uf_rst");
    push("uf_p1", 16'h0009, mk(16'h0009, 3'd1, 4'b0000, 3'd0, 1'b0));
    opc("uf_op", 3'd0,      mk(16'h0009, 3'd1, 4'b0000, 3'd3, 1'b0));
    idle("uf_sticky",       mk(16'h0009, 3'd1, 4'b0000, 3'd3, 1'b0));
    push("uf_clear", 16'h0001, mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_undo;
    rst("undo_rst");
    push("undo_p1", 16'h0010, mk(16'h0010, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("undo_p2", 16'h0004, mk(16'h0004, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("shl_exec", 3'd6,     mk(16'h0004, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("shl_wb",            mk(16'h0100, 3'd1, 4'b0000, 3'd0, 1'b0));
    und("undo_op",            mk(16'h0004, 3'd2, 4'b0000, 3'd0, 1'b0));
    und("undo_twice",         mk(16'h0004, 3'd2, 4'b0000, 3'd4, 1'b0));
    opc("second_exec", 3'd0,  mk(16'h0004, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("second_chk",        mk(16'h0014, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("undo_p3", 16'h0007, mk(16'h0007, 3'd2, 4'b0000, 3'd0, 1'b0));
    und("undo_push",          mk(16'h0014, 3'd1, 4'b0000, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    rst("b2b_rst");
    step("simul_enter_undo", 1'b1, 1'b1, 1'b0, 3'd0, 16'h1234, 1'b0,
         mk(16'h0000, 3'd0, 4'b0000, 3'd4, 1'b0));
    push("b2b_p1", 16'h0002, mk(16'h0002, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("b2b_p2", 16'h0003, mk(16'h0003, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("b2b_exec", 3'd0,    mk(16'h0003, 3'd2, 4'b0000, 3'd1, 1'b1));
    push("enter_in_exec", 16'hAAAA, mk(16'h0005, 3'd1, 4'b0000, 3'd0, 1'b0));
    idle("b2b_settle",       mk(16'h0005, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("b2b_p3", 16'h0001, mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("b2b_exec2", 3'd0,   mk(16'h0001, 3'd2, 4'b0000, 3'd1, 1'b1));
    und("undo_in_exec",      mk(16'h0006, 3'd1, 4'b0000, 3'd0, 1'b0));
    und("undo_after_exec",   mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("rst_exec", 3'd0,    mk(16'h0001, 3'd2, 4'b0000, 3'd1, 1'b1));
    rst("rst_in_exec");
    idle("rst_after",        mk(16'h0000, 3'd0, 4'b0000, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  task automatic test_shift_mul;
    rst("sh_rst");
    push("shr_p1", 16'h8000, mk(16'h8000, 3'd1, 4'b0000, 3'd0, 1'b0));
    push("shr_p2", 16'h0010, mk(16'h0010, 3'd2, 4'b0000, 3'd0, 1'b0));
    opc("shr16_exec", 3'd7,  mk(16'h0010, 3'd2, 4'b0000, 3'd1, 1'b1));
    idle("shr16_wb",         mk(16'h0000, 3'd1, 4'b0100, 3'd0, 1'b0));
    push("shr_p3", 16'h8000, mk(16'h8000, 3'd2, 4'b0100, 3'd0, 1'b0));
    push("shr_p4", 16'h000F, mk(16'h000F, 3'd3, 4'b0100, 3'd0, 1'b0));
    opc("shr15_exec", 3'd7,  mk(16'h000F, 3'd3, 4'b0100, 3'd1, 1'b1));
    idle("shr15_wb",         mk(16'h0001, 3'd2, 4'b0000, 3'd0, 1'b0));
    push("shl_p1", 16'h0010, mk(16'h0010, 3'd3, 4'b0000, 3'd0, 1'b0));
    opc("shl16_exec", 3'd6,  mk(16'h0010, 3'd3, 4'b0000, 3'd1, 1'b1));
    idle("shl16_wb",         mk(16'h0000, 3'd2, 4'b0100, 3'd0, 1'b0));
    push("mul_p1", 16'h0100, mk(16'h0100, 3'd3, 4'b0100, 3'd0, 1'b0));
    push("mul_p2", 16'h0100, mk(16'h0100, 3'd4, 4'b0100, 3'd0, 1'b0));
    opc("mul_exec", 3'd2,    mk(16'h0100, 3'd4, 4'b0100, 3'd1, 1'b1));
    idle("mul_wb",           mk(16'h0000, 3'd3, 4'b0110, 3'd0, 1'b0));
    while (exp_q.size() > 0) begin
      snap_t e = exp_q.pop_front(), o = obs_q.pop_front();
      string n = nm_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got top=%h depth=%0d flags=%b status=%0d busy=%b, want top=%h depth=%0d flags=%b status=%0d busy=%b",
                 n, o.top, o.depth, o.flags, o.status, o.busy, e.top, e.depth, e.flags, e.status, e.busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_overflow;
    test_errors;
    test_undo;
    test_back_to_back;
    test_shift_mul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
